// File: rtl/imem_resp.sv
// Instruction-memory fetch responder: synchronous-read word array feeding a
// 4-entry in-order response FIFO with flush, load port and fault reporting.
module imem_resp #(
   parameter int ADDR     = 16,
   parameter int WORD     = 32,
   parameter int MEM_LOG2 = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic [ADDR:0]       req_addr,
   output logic                req_ready,
   output logic                rsp_valid,
   output logic [WORD-1:0]     rsp_data,
   output logic                rsp_err,
   input  logic                rsp_ready,
   input  logic                flush,
   input  logic                ld_we,
   input  logic [MEM_LOG2-1:0] ld_addr,
   input  logic [WORD-1:0]     ld_data
);

   localparam int DEPTH = 1 << MEM_LOG2;

   // A fetch faults when misaligned or when any byte-address bit above the array is set.
   function automatic logic fetch_fault(input logic [ADDR:0] addr);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr[1:0] != 2'b00);
      out_of_range = ((addr >> (MEM_LOG2 + 2)) != {(ADDR+1){1'b0}});
      return misaligned | out_of_range;
   endfunction

   logic [WORD-1:0]     r_mem [DEPTH];
   logic [WORD-1:0]     r_rd_data;
   logic                r_inflight;
   logic                r_inflight_err;

   logic [WORD-1:0]     r_fifo_data [4];
   logic [3:0]          r_fifo_err;
   logic [1:0]          r_wr_ptr;
   logic [1:0]          r_rd_ptr;
   logic [2:0]          r_count;

   logic                r_req_ready;
   logic                r_rsp_valid;
   logic [WORD-1:0]     r_rsp_data;
   logic                r_rsp_err;

   logic                w_accept;
   logic [MEM_LOG2-1:0] w_rd_idx;
   logic                w_push;
   logic                w_pop;
   logic [WORD-1:0]     w_push_data;
   logic [1:0]          w_wr_ptr_nxt;
   logic [1:0]          w_rd_ptr_nxt;
   logic [2:0]          w_count_nxt;
   logic [2:0]          w_outstanding_nxt;
   logic                w_req_ready_nxt;
   logic                w_rsp_valid_nxt;
   logic [WORD-1:0]     w_rsp_data_nxt;
   logic                w_rsp_err_nxt;

   assign w_accept    = req_valid & r_req_ready;
   assign w_rd_idx    = req_addr[MEM_LOG2+1:2];
   assign w_push      = r_inflight & ~flush;
   assign w_pop       = r_rsp_valid & rsp_ready & ~flush;
   assign w_push_data = r_inflight_err ? {WORD{1'b0}} : r_rd_data;

   // Program load and fetch read share an edge, so a same-cycle read sees the old word.
   always_ff @(posedge clk) begin
      if (ld_we) begin
         r_mem[ld_addr] <= ld_data;
      end
      if (w_accept) begin
         r_rd_data <= r_mem[w_rd_idx];
      end
   end

   // Next FIFO bookkeeping; a flush drops everything already queued or in flight.
   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_count_nxt  = r_count;
      if (flush) begin
         w_wr_ptr_nxt = 2'd0;
         w_rd_ptr_nxt = 2'd0;
         w_count_nxt  = 3'd0;
      end else begin
         if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + 2'd1;
         end else begin
            w_wr_ptr_nxt = r_wr_ptr;
         end
         if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + 2'd1;
         end else begin
            w_rd_ptr_nxt = r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 3'd1;
            2'b01:   w_count_nxt = r_count - 3'd1;
            default: w_count_nxt = r_count;
         endcase
      end
   end

   // Ready and head-of-queue outputs are precomputed so they leave the block registered.
   always_comb begin
      w_outstanding_nxt = {2'b00, w_accept} + w_count_nxt;
      w_req_ready_nxt   = (w_outstanding_nxt < 3'd4);
      w_rsp_valid_nxt   = 1'b0;
      w_rsp_data_nxt    = {WORD{1'b0}};
      w_rsp_err_nxt     = 1'b0;
      if (w_count_nxt == 3'd0) begin
         w_rsp_valid_nxt = 1'b0;
         w_rsp_data_nxt  = {WORD{1'b0}};
         w_rsp_err_nxt   = 1'b0;
      end else if (w_push && (w_count_nxt == 3'd1)) begin
         // The only entry left after this edge is the one being pushed now.
         w_rsp_valid_nxt = 1'b1;
         w_rsp_data_nxt  = w_push_data;
         w_rsp_err_nxt   = r_inflight_err;
      end else begin
         w_rsp_valid_nxt = 1'b1;
         w_rsp_data_nxt  = r_fifo_data[w_rd_ptr_nxt];
         w_rsp_err_nxt   = r_fifo_err[w_rd_ptr_nxt];
      end
   end

   // FIFO payload storage; stale slots are harmless because occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= w_push_data;
         r_fifo_err[r_wr_ptr]  <= r_inflight_err;
      end
   end

   // Control state; reset has the same discarding effect as a flush and also blocks requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight     <= 1'b0;
         r_inflight_err <= 1'b0;
         r_wr_ptr       <= 2'd0;
         r_rd_ptr       <= 2'd0;
         r_count        <= 3'd0;
         r_req_ready    <= 1'b0;
         r_rsp_valid    <= 1'b0;
         r_rsp_data     <= {WORD{1'b0}};
         r_rsp_err      <= 1'b0;
      end else begin
         r_inflight     <= w_accept;
         r_inflight_err <= fetch_fault(req_addr);
         r_wr_ptr       <= w_wr_ptr_nxt;
         r_rd_ptr       <= w_rd_ptr_nxt;
         r_count        <= w_count_nxt;
         r_req_ready    <= w_req_ready_nxt;
         r_rsp_valid    <= w_rsp_valid_nxt;
         r_rsp_data     <= w_rsp_data_nxt;
         r_rsp_err      <= w_rsp_err_nxt;
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_imem_resp.sv
// Directed self-checking bench for imem_resp with hand-computed expectations.
module tb_imem_resp;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [16:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        rsp_ready;
   logic        flush;
   logic        ld_we;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;

   int n_total;
   int n_bad;

   imem_resp #(.ADDR(16), .WORD(32), .MEM_LOG2(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rsp_ready (rsp_ready),
      .flush     (flush),
      .ld_we     (ld_we),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total = n_total + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // advance one edge and settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [9:0] a, input logic [31:0] d);
      ld_we   = 1'b1;
      ld_addr = a;
      ld_data = d;
      step();
      ld_we   = 1'b0;
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d, input logic e);
      chk({tag, "_valid"}, {63'd0, rsp_valid}, {63'd0, v});
      chk({tag, "_data"},  {32'd0, rsp_data},  {32'd0, d});
      chk({tag, "_err"},   {63'd0, rsp_err},   {63'd0, e});
   endtask

   initial begin
      n_total   = 0;
      n_bad     = 0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = 17'd0;
      rsp_ready = 1'b0;
      flush     = 1'b0;
      ld_we     = 1'b0;
      ld_addr   = 10'd0;
      ld_data   = 32'd0;

      // program load while reset is held
      step();
      load(10'd0, 32'h0000_0013);
      load(10'd1, 32'h00A0_0093);
      load(10'd2, 32'h1111_1111);
      load(10'd3, 32'h3333_3333);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
      chk_rsp("rst", 1'b0, 32'd0, 1'b0);

      rst = 1'b0;
      step();
      chk("post_rst_ready", {63'd0, req_ready}, 64'd1);

      // two back-to-back fetches, latency 2
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr  = 17'h0;
      step();
      chk("lat_e1_valid", {63'd0, rsp_valid}, 64'd0);
      req_addr = 17'h4;
      step();
      req_valid = 1'b0;
      chk_rsp("fetch0", 1'b1, 32'h0000_0013, 1'b0);
      step();
      chk_rsp("fetch4", 1'b1, 32'h00A0_0093, 1'b0);
      step();
      chk("drain_valid", {63'd0, rsp_valid}, 64'd0);

      // misaligned and out-of-range faults
      req_valid = 1'b1;
      req_addr  = 17'h2;
      step();
      req_valid = 1'b0;
      step();
      chk_rsp("misalign", 1'b1, 32'd0, 1'b1);
      req_valid = 1'b1;
      req_addr  = 17'h1000;
      step();
      req_valid = 1'b0;
      step();
      chk_rsp("range", 1'b1, 32'd0, 1'b1);
      step();
      chk("fault_drain", {63'd0, rsp_valid}, 64'd0);

      // backpressure: only four outstanding accepted
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         req_addr = 17'(i * 4);
         chk($sformatf("bp_ready%0d", i), {63'd0, req_ready}, (i < 4) ? 64'd1 : 64'd0);
         step();
      end
      req_valid = 1'b0;
      chk("bp_full_ready", {63'd0, req_ready}, 64'd0);
      chk_rsp("bp_head", 1'b1, 32'h0000_0013, 1'b0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("bp_pop_ready", {63'd0, req_ready}, 64'd1);
      chk_rsp("bp_q1", 1'b1, 32'h00A0_0093, 1'b0);
      rsp_ready = 1'b1;
      step();
      chk_rsp("bp_q2", 1'b1, 32'h1111_1111, 1'b0);
      step();
      chk_rsp("bp_q3", 1'b1, 32'h3333_3333, 1'b0);
      step();
      chk("bp_no_fifth", {63'd0, rsp_valid}, 64'd0);

      // flush with three queued plus a same-cycle request to word 2
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr  = 17'h0;
      step();
      req_addr = 17'h4;
      step();
      req_addr = 17'hC;
      step();
      req_valid = 1'b0;
      step();
      chk_rsp("pre_flush", 1'b1, 32'h0000_0013, 1'b0);
      flush     = 1'b1;
      req_valid = 1'b1;
      req_addr  = 17'h8;
      step();
      flush     = 1'b0;
      req_valid = 1'b0;
      chk("flush_valid", {63'd0, rsp_valid}, 64'd0);
      step();
      chk_rsp("post_flush", 1'b1, 32'h1111_1111, 1'b0);
      rsp_ready = 1'b1;
      step();
      chk("flush_only_one", {63'd0, rsp_valid}, 64'd0);

      // same-cycle load and fetch of word 3
      req_valid = 1'b1;
      req_addr  = 17'hC;
      ld_we     = 1'b1;
      ld_addr   = 10'd3;
      ld_data   = 32'hDEAD_BEEF;
      step();
      req_valid = 1'b0;
      ld_we     = 1'b0;
      step();
      chk_rsp("ld_old", 1'b1, 32'h3333_3333, 1'b0);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      chk_rsp("ld_new", 1'b1, 32'hDEAD_BEEF, 1'b0);
      step();

      // streaming: one request and one response per cycle
      req_valid = 1'b1;
      req_addr  = 17'h0;
      chk("stream_rdy0", {63'd0, req_ready}, 64'd1);
      step();
      req_addr = 17'h4;
      chk("stream_rdy1", {63'd0, req_ready}, 64'd1);
      step();
      chk_rsp("stream0", 1'b1, 32'h0000_0013, 1'b0);
      req_addr = 17'h8;
      chk("stream_rdy2", {63'd0, req_ready}, 64'd1);
      step();
      chk_rsp("stream1", 1'b1, 32'h00A0_0093, 1'b0);
      req_addr = 17'hC;
      chk("stream_rdy3", {63'd0, req_ready}, 64'd1);
      step();
      req_valid = 1'b0;
      chk_rsp("stream2", 1'b1, 32'h1111_1111, 1'b0);
      step();
      chk_rsp("stream3", 1'b1, 32'hDEAD_BEEF, 1'b0);
      step();
      chk("stream_end", {63'd0, rsp_valid}, 64'd0);

      // reset with two responses pending
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_addr  = 17'h0;
      step();
      req_addr = 17'h4;
      step();
      req_valid = 1'b0;
      step();
      chk_rsp("pre_rst", 1'b1, 32'h0000_0013, 1'b0);
      rst = 1'b1;
      step();
      chk("midrst_valid", {63'd0, rsp_valid}, 64'd0);
      chk("midrst_ready", {63'd0, req_ready}, 64'd0);
      rst       = 1'b0;
      rsp_ready = 1'b1;
      step();
      chk("rel_ready", {63'd0, req_ready}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("no_stale%0d", i), {63'd0, rsp_valid}, 64'd0);
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter ADDR, default 16; byte-address MSB index, so address buses are ADDR+1 bits wide.
REQ-002 Parameter WORD, default 32; instruction word width in bits.
REQ-003 Parameter MEM_LOG2, default 10; memory holds 2^MEM_LOG2 words.
REQ-004 clk  input  1  sole clock; all state updates on the posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  fetch request present.
REQ-007 req_addr  input  ADDR+1  fetch byte address.
REQ-008 req_ready  output  1  responder can accept a request this cycle.
REQ-009 rsp_valid  output  1  response at FIFO head is valid.
REQ-010 rsp_data  output  WORD  instruction word; 0 when rsp_err is 1.
REQ-011 rsp_err  output  1  fetch fault: misaligned or out of range.
REQ-012 rsp_ready  input  1  consumer takes the head response.
REQ-013 flush  input  1  discard all outstanding responses (redirect).
REQ-014 ld_we  input  1  program-load write enable.
REQ-015 ld_addr  input  MEM_LOG2  program-load word index.
REQ-016 ld_data  input  WORD  program-load data.

Function
REQ-017 A request is accepted when req_valid and req_ready are both 1 at a posedge.
REQ-018 The memory shall be a synchronous-read word array; the read is indexed by req_addr[MEM_LOG2+1:2].
REQ-019 Latency: a request accepted at edge E shall have its response enter the 4-entry output FIFO at edge E+1, so rsp_valid may first be 1 in the cycle after E+1.
REQ-020 A response is popped when rsp_valid and rsp_ready are both 1 at a posedge; the next entry appears in the following cycle.
REQ-021 Responses shall be delivered strictly in request order.
REQ-022 outstanding = in-flight reads (0 or 1) + FIFO occupancy (0..4).
REQ-023 req_ready = (outstanding < 4); it is derived from state only and never from rsp_ready.
REQ-024 With rsp_ready held at 1, the block shall sustain one accepted request and one response per cycle.
REQ-025 req_addr[1:0] != 0 shall produce a response with rsp_err=1 and rsp_data=0.
REQ-026 req_addr[ADDR:MEM_LOG2+2] != 0 shall produce a response with rsp_err=1 and rsp_data=0.
REQ-027 ld_we=1 at a posedge shall write ld_data to word ld_addr.
REQ-028 A same-cycle load and fetch to the same word shall return the old data; the new data is returned from the next cycle on.
REQ-029 flush=1 at a posedge shall empty the FIFO, cancel any in-flight read, and drive rsp_valid=0 in the next cycle.
REQ-030 A request accepted in the same cycle as flush shall be retained as post-flush work; its response appears normally.
REQ-031 rsp_ready is ignored while rsp_valid=0; a pop and a FIFO push in the same cycle leave occupancy unchanged.
REQ-032 The FIFO pointers shall wrap modulo 4; overflow is impossible by REQ-023.

Reset
REQ-033 While rst=1: FIFO empty, in-flight cleared, rsp_valid=0, rsp_err=0, rsp_data=0, and req_ready=0.
REQ-034 req_ready=1 shall hold from the first cycle after rst deasserts.
REQ-035 Reset asserted mid-operation shall discard all outstanding responses, with the same effect as flush.
REQ-036 Memory contents are not affected by rst.
REQ-037 ld_we is honoured even while rst=1.

Verification
REQ-038 Load word 0 = 0x00000013 and word 1 = 0x00A00093; fetch 0x0 then 0x4 with rsp_ready=1 -> responses 0x00000013 then 0x00A00093 at latency 2, no errors.
REQ-039 Hold rsp_ready=0 and issue 5 requests -> 4 accepted, req_ready=0 on the fifth; then pop one -> req_ready=1 in the next cycle.
REQ-040 Fetch 0x2 -> rsp_err=1, rsp_data=0; with MEM_LOG2=10, fetch 0x1000 -> rsp_err=1.
REQ-041 Three responses queued, then flush plus a new request to 0x8 in the same cycle -> only the word-2 response is delivered.
REQ-042 ld_we to word 3 with value 0xDEADBEEF in the same cycle as a fetch of 0xC -> the fetch returns the old value; a refetch returns 0xDEADBEEF.
REQ-043 Assert rst with 2 responses pending -> rsp_valid=0 in the next cycle, and no stale response appears after reset is released.
